mmcm_clksel_seq: RTL

MMCM_CLKSEL_SEQ -- requirements
Module: mmcm_clksel_seq

---
 rtl/mmcm_clksel_seq.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mmcm_clksel_seq.sv
// rtl/mmcm_clksel_seq.sv - MMCM input clock select switch with reset, lock wait and retry sequencing
module mmcm_clksel_seq #(
   parameter logic INIT_SEL      = 1'b0,
   parameter int   SETTLE_CYCLES = 4,
   parameter int   RST_CYCLES    = 16,
   parameter int   LOCK_TIMEOUT  = 50000,
   parameter int   MAX_RETRY     = 3
) (
   input  logic clk,
   input  logic resetn,
   input  logic req,
   input  logic req_sel,
   input  logic locked,
   output logic mmcm_rst,
   output logic clk_in_sel,
   output logic ready,
   output logic done,
   output logic err,
   output logic locked_q
);

   typedef enum logic [2:0] {
      ST_PRE,
      ST_SEL,
      ST_WAIT_LOCK,
      ST_READY,
      ST_FAIL
   } state_t;

   localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
   localparam logic [15:0] RST_LAST     = 16'(RST_CYCLES - 1);
   localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
   localparam logic [4:0]  RETRY_LIM    = 5'(MAX_RETRY);

   state_t      state;
   state_t      state_nxt;
   logic [15:0] cnt;
   logic [15:0] cnt_nxt;
   logic [3:0]  rtry;
   logic [3:0]  rtry_nxt;
   logic [4:0]  rtry_inc;
   logic        pending;
   logic        pending_nxt;
   logic        sel_load;
   logic        done_q;
   logic        done_nxt;
   logic        lock_hit;
   logic        locked_m;
   logic        locked_s;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         locked_m <= 1'b0;
         locked_s <= 1'b0;
      end else begin
         locked_m <= locked;
         locked_s <= locked_m;
      end
   end

   // mmcm_rst is registered from the next state so the MMCM reset pin never glitches
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= ST_SEL;
         cnt        <= '0;
         rtry       <= '0;
         pending    <= INIT_SEL;
         clk_in_sel <= INIT_SEL;
         mmcm_rst   <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         rtry     <= rtry_nxt;
         pending  <= pending_nxt;
         done_q   <= done_nxt;
         mmcm_rst <= !(state_nxt == ST_WAIT_LOCK || state_nxt == ST_READY);
         if (sel_load) begin
            clk_in_sel <= pending;
         end
      end
   end

   assign rtry_inc = {1'b0, rtry} + 5'd1;

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt + 16'd1;
      rtry_nxt    = rtry;
      pending_nxt = pending;
      done_nxt    = 1'b0;
      sel_load    = 1'b0;
      case (state)
         ST_PRE: begin
            if (cnt == SETTLE_LAST) begin
               state_nxt = ST_SEL;
               cnt_nxt   = '0;
               sel_load  = 1'b1;
            end
         end
         ST_SEL: begin
            if (cnt == RST_LAST) begin
               state_nxt = ST_WAIT_LOCK;
               cnt_nxt   = '0;
            end
         end
         ST_WAIT_LOCK: begin
            // a lock arriving on the timeout cycle still counts as success
            if (locked_s) begin
               state_nxt = ST_READY;
               cnt_nxt   = '0;
               rtry_nxt  = '0;
            end else if (cnt == TIMEOUT_LAST) begin
               cnt_nxt   = '0;
               rtry_nxt  = rtry_inc[3:0];
               state_nxt = (rtry_inc < RETRY_LIM) ? ST_PRE : ST_FAIL;
            end
         end
         ST_READY: begin
            cnt_nxt = '0;
            if (req && (req_sel != clk_in_sel || !locked_s)) begin
               pending_nxt = req_sel;
               rtry_nxt    = '0;
               state_nxt   = ST_PRE;
            end else if (req) begin
               done_nxt = 1'b1;
            end else if (!locked_s) begin
               pending_nxt = clk_in_sel;
               rtry_nxt    = '0;
               state_nxt   = ST_PRE;
            end
         end
         ST_FAIL: begin
            cnt_nxt = '0;
            if (req) begin
               pending_nxt = req_sel;
               rtry_nxt    = '0;
               state_nxt   = ST_PRE;
            end
         end
         default: begin
            state_nxt = ST_SEL;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign lock_hit = (state == ST_WAIT_LOCK) && locked_s;
   assign done     = done_q | lock_hit;
   assign ready    = (state == ST_READY) || (state == ST_FAIL);
   assign err      = (state == ST_FAIL);
   assign locked_q = locked_s && (state == ST_READY);

endmodule
